// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and opcode constants for the instruction fetch stage.
package fetch_unit_pkg;
  typedef logic [15:0] addr_t;
  typedef logic [7:0] data_t;
  typedef logic [1:0] ilen_t;
  typedef enum logic [2:0] {IDLE, OPC, OPL, OPH, DONE} fetch_state_t;
  localparam data_t BRK_OP = 8'h00;
  localparam data_t JSR_OP = 8'h20;
  localparam data_t RTI_OP = 8'h40;
  localparam data_t RTS_OP = 8'h60;
endpackage

// File: rtl/fetch_unit_oplen.sv
// oplen_decode: 6502 opcode to instruction length (1..3 bytes).
module oplen_decode
  import fetch_unit_pkg::*;
(
  input  data_t op_i,
  output ilen_t ilen_o
);
  logic [3:0] lo;
  assign lo = op_i[3:0];
  always_comb
    ilen_o = (op_i inside {BRK_OP, RTI_OP, RTS_OP})                ? 2'd1 :
             (op_i == JSR_OP)                                       ? 2'd3 :
             (lo inside {4'hC, 4'hD, 4'hE} || (lo == 4'h9 && op_i[4])) ? 2'd3 :
             (lo inside {4'h8, 4'hA, 4'h3, 4'h7, 4'hB, 4'hF})       ? 2'd1 :
                                                                      2'd2;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: 6502 fetch stage; owns the PC and gathers opcode plus operand bytes.
// Define FETCH_REL_EN to resolve relative-branch targets into operand.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter addr_t RESET_PC = 16'h0000,
  parameter int    MEM_LAT  = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  fetch,
  input  logic  pc_load,
  input  addr_t pc_load_val,
  input  data_t mem_data,
  output addr_t pc_out,
  output data_t opcode,
  output addr_t operand,
  output ilen_t ilen,
  output logic  busy,
  output logic  ready
);
  localparam logic [1:0] LAT = 2'(MEM_LAT);
  fetch_state_t state_q;
  logic [1:0] wc_q;
  addr_t pc_q, operand_q, pc_d, lo_operand;
  data_t opcode_q;
  ilen_t ilen_q, dec_ilen;
  logic hit;
  oplen_decode u_dec (.op_i(mem_data), .ilen_o(dec_ilen));
  assign pc_d = pc_q + 16'd1;
  assign hit  = wc_q == LAT;
`ifdef FETCH_REL_EN
  // pc_d is the address just past the offset byte, i.e. the branch base
  assign lo_operand = (opcode_q[4:0] == 5'b10000) ? pc_d + {{8{mem_data[7]}}, mem_data}
                                                  : {8'h00, mem_data};
`else
  assign lo_operand = {8'h00, mem_data};
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wc_q      <= '0;
      pc_q      <= RESET_PC;
      opcode_q  <= '0;
      operand_q <= '0;
      ilen_q    <= 2'd1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (pc_load) pc_q <= pc_load_val;
          wc_q    <= '0;
          state_q <= fetch ? OPC : IDLE;
        end
        OPC: begin
          wc_q <= hit ? 2'd0 : wc_q + 2'd1;
          if (hit) begin
            opcode_q  <= mem_data;
            ilen_q    <= dec_ilen;
            operand_q <= '0;
            pc_q      <= pc_d;
            state_q   <= (dec_ilen == 2'd1) ? DONE : OPL;
          end
        end
        OPL: begin
          wc_q <= hit ? 2'd0 : wc_q + 2'd1;
          if (hit) begin
            operand_q <= lo_operand;
            pc_q      <= pc_d;
            state_q   <= (ilen_q == 2'd3) ? OPH : DONE;
          end
        end
        OPH: begin
          wc_q <= hit ? 2'd0 : wc_q + 2'd1;
          if (hit) begin
            operand_q[15:8] <= mem_data;
            pc_q            <= pc_d;
            state_q         <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign pc_out  = pc_q;
  assign opcode  = opcode_q;
  assign operand = operand_q;
  assign ilen    = ilen_q;
  assign busy    = state_q inside {OPC, OPL, OPH};
  assign ready   = state_q == DONE;
  a_load_busy: assert property (@(posedge clk) disable iff (!rst_n) !(pc_load && busy));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with registered memory models (latency 1, 2, 3).
module tb_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic fetch = 1'b0, pc_load = 1'b0, f23 = 1'b0, l23 = 1'b0;
  logic [15:0] pc_load_val = '0, v23 = '0;
  logic [7:0] mem [0:65535];
  logic [7:0] p1, p2 [2], p3 [3];
  logic [15:0] pc1, pc2, pc3, op1, op2, op3;
  logic [7:0] opc1, opc2, opc3;
  logic [1:0] il1, il2, il3;
  logic b1, b2, b3, r1, r2, r3;
  int total = 0, bad = 0;
  int n, n2, n3;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1    <= mem[pc1];
    p2[0] <= mem[pc2];
    p2[1] <= p2[0];
    p3[0] <= mem[pc3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  fetch_unit #(.MEM_LAT(1)) dut (.clk(clk), .rst_n(rst_n), .fetch(fetch), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .mem_data(p1), .pc_out(pc1), .opcode(opc1), .operand(op1),
    .ilen(il1), .busy(b1), .ready(r1));
  fetch_unit #(.MEM_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .fetch(f23), .pc_load(l23),
    .pc_load_val(v23), .mem_data(p2[1]), .pc_out(pc2), .opcode(opc2), .operand(op2),
    .ilen(il2), .busy(b2), .ready(r2));
  fetch_unit #(.MEM_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .fetch(f23), .pc_load(l23),
    .pc_load_val(v23), .mem_data(p3[2]), .pc_out(pc3), .opcode(opc3), .operand(op3),
    .ilen(il3), .busy(b3), .ready(r3));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic [15:0] val);
    fetch = 1'b1;
    pc_load = ld;
    pc_load_val = val;
    @(posedge clk); #1;
    fetch = 1'b0;
    pc_load = 1'b0;
  endtask

  task automatic wait_ready(input int poke, output int cnt);
    cnt = 0;
    repeat (40) begin
      fetch = (cnt == poke);
      @(posedge clk); #1;
      cnt++;
      if (r1) break;
    end
    fetch = 1'b0;
  endtask

  initial begin
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h42;
    mem[16'h0002] = 8'h4C; mem[16'h0003] = 8'h34; mem[16'h0004] = 8'h12;
    mem[16'hFFFF] = 8'hAD;
    mem[16'h0200] = 8'hF0; mem[16'h0201] = 8'hFE;
    mem[16'hFFF0] = 8'hF0; mem[16'hFFF1] = 8'h7F;
    repeat (2) @(posedge clk);
    #1 chk("por_pc", pc1, 16'h0000);
    chk("por_ilen", 16'(il1), 16'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // test 1: reset during OPL of 4C 34 12
    issue(1'b1, 16'h0002);
    repeat (2) @(posedge clk);
    #1 chk("t1_opc_pre", 16'(opc1), 16'h004C);
    chk("t1_busy_pre", 16'(b1), 16'd1);
    #2 rst_n = 1'b0;
    #1 chk("t1_rst_pc", pc1, 16'h0000);
    chk("t1_rst_opc", 16'(opc1), 16'h0000);
    chk("t1_rst_operand", op1, 16'h0000);
    chk("t1_rst_ilen", 16'(il1), 16'd1);
    chk("t1_rst_busy", 16'(b1), 16'd0);
    chk("t1_rst_ready", 16'(r1), 16'd0);
    @(posedge clk); #4 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t1_post_ready", 16'(r1), 16'd0);
    chk("t1_post_pc", pc1, 16'h0000);
    // test 2: immediate from RESET_PC
    issue(1'b0, 16'h0000);
    wait_ready(-1, n);
    chk("t2_cycles", 16'(n), 16'd4);
    chk("t2_opc", 16'(opc1), 16'h00A9);
    chk("t2_ilen", 16'(il1), 16'd2);
    chk("t2_operand", op1, 16'h0042);
    chk("t2_pc", pc1, 16'h0002);
    chk("t2_busy", 16'(b1), 16'd0);
    // test 3: back-to-back absolute with an ignored mid-instruction fetch
    issue(1'b0, 16'h0000);
    wait_ready(2, n);
    chk("t3_cycles", 16'(n), 16'd6);
    chk("t3_opc", 16'(opc1), 16'h004C);
    chk("t3_ilen", 16'(il1), 16'd3);
    chk("t3_operand", op1, 16'h1234);
    chk("t3_pc", pc1, 16'h0005);
    @(posedge clk); #1;
    chk("t3_ready_pulse", 16'(r1), 16'd0);
    chk("t3_idle_busy", 16'(b1), 16'd0);
    chk("t3_hold_operand", op1, 16'h1234);
    // test 4: load+fetch at FFFF with wrap
    mem[16'h0000] = 8'h00; mem[16'h0001] = 8'h10;
    issue(1'b1, 16'hFFFF);
    wait_ready(-1, n);
    chk("t4_cycles", 16'(n), 16'd6);
    chk("t4_opc", 16'(opc1), 16'h00AD);
    chk("t4_ilen", 16'(il1), 16'd3);
    chk("t4_operand", op1, 16'h1000);
    chk("t4_pc", pc1, 16'h0002);
    mem[16'hFFFF] = 8'hEA;
    issue(1'b1, 16'hFFFF);
    wait_ready(-1, n);
    chk("t4b_cycles", 16'(n), 16'd2);
    chk("t4b_opc", 16'(opc1), 16'h00EA);
    chk("t4b_ilen", 16'(il1), 16'd1);
    chk("t4b_operand", op1, 16'h0000);
    chk("t4b_pc", pc1, 16'h0000);
    // test 5: relative branches
    issue(1'b1, 16'h0200);
    wait_ready(-1, n);
    chk("t5_cycles", 16'(n), 16'd4);
    chk("t5_ilen", 16'(il1), 16'd2);
    chk("t5_pc", pc1, 16'h0202);
`ifdef FETCH_REL_EN
    chk("t5_operand", op1, 16'h0200);
`else
    chk("t5_operand", op1, 16'h00FE);
`endif
    issue(1'b1, 16'hFFF0);
    wait_ready(-1, n);
    chk("t5b_pc", pc1, 16'hFFF2);
`ifdef FETCH_REL_EN
    chk("t5b_operand", op1, 16'h0071);
`else
    chk("t5b_operand", op1, 16'h007F);
`endif
    // test 6: latency sweep on JMP abs at 0002
    f23 = 1'b1; l23 = 1'b1; v23 = 16'h0002;
    @(posedge clk); #1;
    f23 = 1'b0; l23 = 1'b0;
    n2 = 0; n3 = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (r2 && n2 == 0) n2 = i;
      if (r3 && n3 == 0) n3 = i;
    end
    chk("t6_lat2_cycles", 16'(n2), 16'd9);
    chk("t6_lat3_cycles", 16'(n3), 16'd12);
    chk("t6_lat2_operand", op2, 16'h1234);
    chk("t6_lat3_operand", op3, 16'h1234);
    chk("t6_lat2_pc", pc2, 16'h0005);
    chk("t6_lat3_pc", pc3, 16'h0005);
    chk("t6_lat3_opc", 16'(opc3), 16'h004C);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
